// File: rtl/note_sequencer.sv
// Melody sequencer: walks an 8-note ROM and drives the
// square-wave divider period word plus an audible gate.
module note_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic        CLOCK50,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  output logic [23:0] frequency,
  output logic        tone_en,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [31:0] BEAT1 = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] BEAT2 = 32'(2 * BEAT_CYCLES - 1);
  localparam logic [31:0] GAPL  = 32'(GAP_CYCLES - 1);

  logic [1:0]  state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [23:0] freq_n;
  logic [2:0]  idx_n;
  logic        ten_n;
  logic        busy_n;
  logic        done_n;
  logic [2:0]  nxt_idx;
  logic [31:0] play_last;

  function automatic logic [23:0] rom(input logic [2:0] i);
    logic [23:0] p;
    p = 24'd0;
    unique case (i)
      3'd0: p = 24'd191110;
      3'd1: p = 24'd170265;
      3'd2: p = 24'd151686;
      3'd3: p = 24'd143172;
      3'd4: p = 24'd127551;
      3'd5: p = 24'd113636;
      3'd6: p = 24'd101239;
      3'd7: p = 24'd95556;
    endcase
    return p;
  endfunction

  // Index 7 wraps to 0, which is exactly the loop restart
  assign nxt_idx   = note_idx + 3'd1;
  assign play_last = (note_idx == 3'd7) ? BEAT2 : BEAT1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    freq_n  = frequency;
    idx_n   = note_idx;
    ten_n   = tone_en;
    busy_n  = busy;
    done_n  = 1'b0;
    if (stop) begin
      state_n = S_IDLE;
      cnt_n   = 32'd0;
      ten_n   = 1'b0;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_n = S_PLAY;
            cnt_n   = 32'd0;
            idx_n   = 3'd0;
            freq_n  = rom(3'd0);
            ten_n   = 1'b1;
            busy_n  = 1'b1;
          end
        end
        S_PLAY: begin
          if (cnt == play_last) begin
            state_n = S_GAP;
            cnt_n   = 32'd0;
            ten_n   = 1'b0;
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAPL) begin
            cnt_n = 32'd0;
            if (note_idx != 3'd7 || loop) begin
              state_n = S_PLAY;
              idx_n   = nxt_idx;
              freq_n  = rom(nxt_idx);
              ten_n   = 1'b1;
            end else begin
              state_n = S_IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + 32'd1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = 32'd0;
          ten_n   = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 32'd0;
      frequency <= 24'd0;
      note_idx  <= 3'd0;
      tone_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      frequency <= freq_n;
      note_idx  <= idx_n;
      tone_en   <= ten_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: checkpoint table per
// scenario, plus done-pulse and done/busy overlap checks.
module tb_note_sequencer;

  logic        CLOCK50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [23:0] f_a, f_b;
  logic        t_a, t_b;
  logic [2:0]  n_a, n_b;
  logic        b_a, b_b;
  logic        d_a, d_b;

  always #10 CLOCK50 = ~CLOCK50;

  note_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2)) dut_a (
    .CLOCK50(CLOCK50), .reset(reset), .start(start),
    .stop(stop), .loop(loop), .frequency(f_a),
    .tone_en(t_a), .note_idx(n_a), .busy(b_a), .done(d_a)
  );

  note_sequencer #(.BEAT_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .CLOCK50(CLOCK50), .reset(reset), .start(start),
    .stop(stop), .loop(loop), .frequency(f_b),
    .tone_en(t_b), .note_idx(n_b), .busy(b_b), .done(d_b)
  );

  typedef struct {
    int          id;
    int          cyc;
    logic [23:0] freq;
    logic        ten;
    logic [2:0]  idx;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nbad = 0;

  task automatic add(input int id, input int cyc,
                     input int fr, input bit te,
                     input int ix, input bit bz,
                     input bit dn);
    vec_t v;
    v.id = id; v.cyc = cyc; v.freq = 24'(fr);
    v.ten = te; v.idx = 3'(ix); v.busy = bz; v.done = dn;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int c,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s cyc%0d: got %0d want %0d",
               nm, c, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK50);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Cycle n is sampled just after edge n-1; inputs for cycle c
  // are set before edge c.
  task automatic run(input int id, input bit sel,
                     input int ncyc, input int st_to,
                     input int sp_from, input int sp_to,
                     input int rst_at, input bit lp,
                     input int exp_done);
    int dcnt;
    int ovl;
    logic [23:0] f;
    logic t, b, d;
    logic [2:0] n;
    dcnt = 0;
    ovl = 0;
    loop = lp;
    for (int c = 0; c < ncyc; c++) begin
      start = (c <= st_to);
      stop  = (c >= sp_from) && (c <= sp_to);
      reset = (c == rst_at);
      tick();
      f = sel ? f_b : f_a;
      t = sel ? t_b : t_a;
      n = sel ? n_b : n_a;
      b = sel ? b_b : b_a;
      d = sel ? d_b : d_a;
      if (d) dcnt++;
      if (d && b) ovl++;
      foreach (tbl[i]) begin
        if (tbl[i].id == id && tbl[i].cyc == c + 1) begin
          chk($sformatf("t%0d.freq", id), c + 1,
              32'(f), 32'(tbl[i].freq));
          chk($sformatf("t%0d.tone_en", id), c + 1,
              32'(t), 32'(tbl[i].ten));
          chk($sformatf("t%0d.note_idx", id), c + 1,
              32'(n), 32'(tbl[i].idx));
          chk($sformatf("t%0d.busy", id), c + 1,
              32'(b), 32'(tbl[i].busy));
          chk($sformatf("t%0d.done", id), c + 1,
              32'(d), 32'(tbl[i].done));
        end
      end
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0; loop = 1'b0;
    chk($sformatf("t%0d.done_pulses", id), ncyc, dcnt, exp_done);
    chk($sformatf("t%0d.done_with_busy", id), ncyc, ovl, 0);
  endtask

  initial begin
    // 1: single pass, loop=0
    add(1, 1, 191110, 1, 0, 1, 0);
    add(1, 10, 191110, 1, 0, 1, 0);
    add(1, 11, 191110, 0, 0, 1, 0);
    add(1, 12, 191110, 0, 0, 1, 0);
    add(1, 13, 170265, 1, 1, 1, 0);
    add(1, 24, 170265, 0, 1, 1, 0);
    add(1, 25, 151686, 1, 2, 1, 0);
    add(1, 73, 101239, 1, 6, 1, 0);
    add(1, 85, 95556, 1, 7, 1, 0);
    add(1, 104, 95556, 1, 7, 1, 0);
    add(1, 105, 95556, 0, 7, 1, 0);
    add(1, 106, 95556, 0, 7, 1, 0);
    add(1, 107, 95556, 0, 7, 0, 1);
    add(1, 108, 95556, 0, 7, 0, 0);
    // 2: loop=1, second pass repeats the first
    add(2, 106, 95556, 0, 7, 1, 0);
    add(2, 107, 191110, 1, 0, 1, 0);
    add(2, 117, 191110, 0, 0, 1, 0);
    add(2, 119, 170265, 1, 1, 1, 0);
    add(2, 191, 95556, 1, 7, 1, 0);
    add(2, 212, 95556, 0, 7, 1, 0);
    add(2, 213, 191110, 1, 0, 1, 0);
    // 3: stop during note 3, then restart
    add(3, 40, 143172, 1, 3, 1, 0);
    add(3, 41, 143172, 0, 3, 0, 0);
    add(3, 45, 143172, 0, 3, 0, 0);
    add(31, 1, 191110, 1, 0, 1, 0);
    add(31, 13, 170265, 1, 1, 1, 0);
    // 4: start held through play is ignored
    add(4, 13, 170265, 1, 1, 1, 0);
    add(4, 37, 143172, 1, 3, 1, 0);
    add(4, 61, 113636, 1, 5, 1, 0);
    add(4, 107, 95556, 0, 7, 0, 1);
    // 41: start+stop together in idle
    add(41, 1, 95556, 0, 7, 0, 0);
    add(41, 4, 95556, 0, 7, 0, 0);
    add(41, 5, 95556, 0, 7, 0, 0);
    // 5: reset mid-note
    add(5, 50, 127551, 1, 4, 1, 0);
    add(5, 51, 0, 0, 0, 0, 0);
    add(5, 52, 0, 0, 0, 0, 0);
    // 6: stop on the final gap cycle
    add(6, 106, 95556, 0, 7, 1, 0);
    add(6, 107, 95556, 0, 7, 0, 0);
    add(6, 108, 95556, 0, 7, 0, 0);
    // 7: start held across done restarts immediately
    add(7, 107, 95556, 0, 7, 0, 1);
    add(7, 108, 191110, 1, 0, 1, 0);
    // 8: BEAT=1, GAP=1 instance
    add(8, 1, 191110, 1, 0, 1, 0);
    add(8, 2, 191110, 0, 0, 1, 0);
    add(8, 3, 170265, 1, 1, 1, 0);
    add(8, 13, 101239, 1, 6, 1, 0);
    add(8, 14, 101239, 0, 6, 1, 0);
    add(8, 15, 95556, 1, 7, 1, 0);
    add(8, 16, 95556, 1, 7, 1, 0);
    add(8, 17, 95556, 0, 7, 1, 0);
    add(8, 18, 95556, 0, 7, 0, 1);
    add(8, 19, 95556, 0, 7, 0, 0);

    do_reset();
    chk("rst.freq", 0, 32'(f_a), 0);
    chk("rst.tone_en", 0, 32'(t_a), 0);
    chk("rst.note_idx", 0, 32'(n_a), 0);
    chk("rst.busy", 0, 32'(b_a), 0);
    chk("rst.done", 0, 32'(d_a), 0);
    chk("rst.freq_b", 0, 32'(f_b), 0);

    run(1, 0, 110, 0, -1, -2, -1, 0, 1);
    do_reset();
    run(2, 0, 215, 0, -1, -2, -1, 1, 0);
    do_reset();
    run(3, 0, 46, 0, 40, 40, -1, 0, 0);
    run(31, 0, 14, 0, -1, -2, -1, 0, 0);
    do_reset();
    run(4, 0, 110, 60, -1, -2, -1, 0, 1);
    run(41, 0, 5, 3, 0, 3, -1, 0, 0);
    do_reset();
    run(5, 0, 53, 0, -1, -2, 50, 0, 0);
    do_reset();
    run(6, 0, 110, 0, 106, 106, -1, 0, 0);
    do_reset();
    run(7, 0, 109, 200, -1, -2, -1, 0, 1);
    do_reset();
    run(8, 1, 20, 0, -1, -2, -1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream tone-control stage for the square-wave clock divider: steps through a fixed 8-note melody and drives the divider's 24-bit `frequency` word (full tone period in CLOCK50 cycles).
- Also drives a tone_en gate that the audio path uses to mute the divider output between notes and when idle.
- Everything runs in the CLOCK50 domain; there are no clock outputs.

Parameters:
- BEAT_CYCLES, 12_500_000: CLOCK50 cycles per beat (0.25 s). Must be >= 1.
- GAP_CYCLES, 500_000: silent cycles after every note. Must be >= 1.

Ports:
- CLOCK50  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-high; clock CLOCK50
- start  input  1  level-sampled; begins the melody when idle
- stop  input  1  aborts playback
- loop  input  1  sampled at the end of the last gap: 1 = restart at note 0, 0 = finish
- frequency  output  24  period word for the divider; registered
- tone_en  output  1  1 = audible note; registered
- note_idx  output  3  index of the current note; registered
- busy  output  1  1 in PLAY or GAP
- done  output  1  one-cycle pulse when the melody finishes

Behaviour:
- Internal ROM, index: period / beats.
  - 0: 191110 / 1
  - 1: 170265 / 1
  - 2: 151686 / 1
  - 3: 143172 / 1
  - 4: 127551 / 1
  - 5: 113636 / 1
  - 6: 101239 / 1
  - 7: 95556 / 2
- Reset values: state IDLE, frequency 0, tone_en 0, note_idx 0, busy 0, done 0, counter 0.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If start=1 and stop=0 at edge k: after edge k, state PLAY, note_idx 0, frequency 191110, tone_en 1, busy 1, counter cleared.
  - Otherwise stay in IDLE, holding outputs.
- PLAY:
  - tone_en 1. Stays exactly beats*BEAT_CYCLES cycles, counted by a 32-bit counter.
  - On the last cycle, transition to GAP: tone_en 0, and frequency and note_idx are held.
- GAP:
  - Stays exactly GAP_CYCLES cycles.
  - On the last cycle, if note_idx < 7: note_idx+1, frequency = ROM[note_idx+1], tone_en 1, state PLAY.
  - If note_idx = 7 and loop=1: note_idx 0, frequency 191110, state PLAY. No done pulse.
  - If note_idx = 7 and loop=0: state IDLE, busy 0, done=1 for exactly one cycle. frequency holds 95556 and note_idx holds 7 in IDLE.
- frequency, note_idx and tone_en always change on the same edge; there is no cycle where tone_en=1 with a stale frequency.
- stop=1 in any state:
  - Next state IDLE, tone_en 0, busy 0, done 0, counter cleared.
  - frequency and note_idx are held.
  - stop has priority over start and over every PLAY/GAP transition, including the final gap cycle, so no done pulse.
- start while busy: ignored (no restart).
- start held high in IDLE after done: the melody restarts on the next edge. This is legal.
- reset mid-operation: all registers return to reset values on that edge, regardless of the other inputs.
- done is never asserted together with busy.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=2 unless noted):
1. Reset, then start pulse at edge 0, loop=0.
   - Cycles 1-10: tone_en=1, frequency=191110, note_idx=0.
   - Cycles 11-12: tone_en=0, frequency=191110.
   - Cycle 13: frequency=170265, note_idx=1.
   - Note 7 plays cycles 85-104; gap 105-106.
   - done=1 on cycle 107 only; busy=0 from 107.
2. Same run with loop=1 held.
   - Cycle 107: note_idx=0, frequency=191110, tone_en=1, done stays 0.
   - The second pass is identical to the first.
3. stop asserted at cycle 40 (note 3 playing).
   - Cycle 41: state IDLE, tone_en=0, busy=0, frequency holds 143172, no done pulse.
   - A subsequent start restarts at note 0.
4. start held high for cycles 0-60.
   - Melody not restarted mid-play; note progression matches test 1.
   - start and stop both high in IDLE: stays IDLE, busy=0.
5. reset asserted at cycle 50 (any state).
   - Cycle 51: frequency=0, note_idx=0, tone_en=0, busy=0, done=0.
6. stop asserted exactly on the last GAP cycle of note 7 (cycle 106).
   - IDLE next, done never pulses.
   - With GAP_CYCLES=1, BEAT_CYCLES=1: notes advance every 2 cycles, with no off-by-one in either counter.
